// File: rtl/ale_atmos_light_estimator_if.sv
// ale_atmos_light_estimator_if: BGR pixel stream feeding the atmospheric light estimator
interface ale_atmos_light_estimator_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    modport master (output tdata, tvalid, tlast, input tready);
    modport slave (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/ale_atmos_light_estimator.sv
// ale_atmos_light_estimator: tracks the brightest dark-channel pixel of a frame and presents it as atmospheric light
module ale_atmos_light_estimator #(
    parameter int NUM_PIXELS = 262144,
    parameter int CNT_W      = 19
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       enable,
    input  logic                       ale_clear,
    ale_atmos_light_estimator_if.slave s_axis,
    output logic [7:0]                 A_R,
    output logic [7:0]                 A_G,
    output logic [7:0]                 A_B,
    output logic [7:0]                 DC_MAX,
    output logic                       A_VALID,
    output logic                       ALE_DONE,
    output logic                       FRAME_SHORT,
    output logic [CNT_W-1:0]           PIX_COUNT
);
    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(NUM_PIXELS);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       s1_r_q, s1_r_d, s1_g_q, s1_g_d, s1_b_q, s1_b_d, s1_dc_q, s1_dc_d;
    logic [7:0]       max_r_q, max_r_d, max_g_q, max_g_d, max_b_q, max_b_d, max_dc_q, max_dc_d;
    logic             s1_vld_q, s1_vld_d, first_q, first_d, last_q, last_d;
    logic             short_q, short_d, done_q, done_d;
    logic [7:0]       px_r, px_g, px_b, min_rg;
    logic             hs, last, clr, upd, unused_tdata;
    always_comb begin
        px_r          = s_axis.tdata[23:16];
        px_g          = s_axis.tdata[15:8];
        px_b          = s_axis.tdata[7:0];
        min_rg        = px_r < px_g ? px_r : px_g;
        unused_tdata  = ^s_axis.tdata[31:24];
        s_axis.tready = enable & (state_q == ACCUM | state_q == DONE);
        // the beat after the last one is discarded while stage 2 drains into FLUSH
        hs            = s_axis.tvalid & s_axis.tready & (state_q == ACCUM) & !last_q;
        last          = hs & (s_axis.tlast | (cnt_q == LAST_IDX));
        clr           = !enable | (state_q == DONE & ale_clear);
        upd           = s1_vld_q & (first_q | (s1_dc_q > max_dc_q));
        state_d       = clr ? IDLE : state_q == IDLE ? ACCUM : state_q == FLUSH ? DONE :
                        (state_q == ACCUM & last_q) ? FLUSH : state_q;
        cnt_d         = clr ? '0 : (hs & (cnt_q != FULL)) ? cnt_q + 1'b1 : cnt_q;
        s1_vld_d      = !clr & hs;
        s1_r_d        = hs ? px_r : s1_r_q;
        s1_g_d        = hs ? px_g : s1_g_q;
        s1_b_d        = hs ? px_b : s1_b_q;
        s1_dc_d       = hs ? (min_rg < px_b ? min_rg : px_b) : s1_dc_q;
        first_d       = clr | (first_q & !s1_vld_q);
        max_r_d       = clr ? '0 : upd ? s1_r_q : max_r_q;
        max_g_d       = clr ? '0 : upd ? s1_g_q : max_g_q;
        max_b_d       = clr ? '0 : upd ? s1_b_q : max_b_q;
        max_dc_d      = clr ? '0 : upd ? s1_dc_q : max_dc_q;
        last_d        = !clr & last;
        short_d       = clr ? 1'b0 : last ? s_axis.tlast & (cnt_q < LAST_IDX) : short_q;
        done_d        = !clr & (state_q == FLUSH);
        A_R           = max_r_q;
        A_G           = max_g_q;
        A_B           = max_b_q;
        DC_MAX        = max_dc_q;
        A_VALID       = state_q == DONE;
        ALE_DONE      = done_q;
        FRAME_SHORT   = short_q & (state_q == DONE);
        PIX_COUNT     = cnt_q;
    end
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            s1_r_q   <= '0;
            s1_g_q   <= '0;
            s1_b_q   <= '0;
            s1_dc_q  <= '0;
            max_r_q  <= '0;
            max_g_q  <= '0;
            max_b_q  <= '0;
            max_dc_q <= '0;
            s1_vld_q <= 1'b0;
            first_q  <= 1'b1;
            last_q   <= 1'b0;
            short_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            s1_r_q   <= s1_r_d;
            s1_g_q   <= s1_g_d;
            s1_b_q   <= s1_b_d;
            s1_dc_q  <= s1_dc_d;
            max_r_q  <= max_r_d;
            max_g_q  <= max_g_d;
            max_b_q  <= max_b_d;
            max_dc_q <= max_dc_d;
            s1_vld_q <= s1_vld_d;
            first_q  <= first_d;
            last_q   <= last_d;
            short_q  <= short_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_ale_atmos_light_estimator.sv
// tb_ale_atmos_light_estimator: table vectors, corner sequences and random frames against a frame-level model
module tb_ale_atmos_light_estimator;
    localparam int NP = 16;
    localparam int CW = 5;
    logic ACLK = 1'b0, ARESETn = 1'b0, enable = 1'b0, ale_clear = 1'b0;
    logic [7:0] A_R, A_G, A_B, DC_MAX;
    logic A_VALID, ALE_DONE, FRAME_SHORT;
    logic [CW-1:0] PIX_COUNT;
    int n_cmp = 0, n_bad = 0;
    logic [23:0] pix [64];
    logic tl [64];
    int m_r, m_g, m_b, m_dc, m_len, m_short;
    typedef struct {
        int base; int h1; int p1; int h2; int p2; int tla; int gap; int top;
        int er; int eg; int eb; int edc; int esh; int ecnt;
    } vec_t;
    vec_t vt [8];

    ale_atmos_light_estimator_if axis();
    ale_atmos_light_estimator #(.NUM_PIXELS(NP), .CNT_W(CW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .enable(enable), .ale_clear(ale_clear), .s_axis(axis),
        .A_R(A_R), .A_G(A_G), .A_B(A_B), .DC_MAX(DC_MAX), .A_VALID(A_VALID),
        .ALE_DONE(ALE_DONE), .FRAME_SHORT(FRAME_SHORT), .PIX_COUNT(PIX_COUNT)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int min3(input logic [23:0] p);
        int r, g, b, m;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        m = r;
        if (g < m) m = g;
        if (b < m) m = b;
        return m;
    endfunction

    // frame length from TLAST/size, then the earliest pixel holding the largest dark channel
    function automatic void model();
        int best;
        bit found;
        m_len = NP;
        m_short = 0;
        found = 0;
        for (int i = 0; i < NP; i++)
            if (!found && tl[i]) begin
                found = 1;
                m_len = i + 1;
                m_short = (i + 1 < NP) ? 1 : 0;
            end
        best = 0;
        for (int j = 1; j < m_len; j++)
            if (min3(pix[j]) > min3(pix[best])) best = j;
        m_r = int'(pix[best][23:16]);
        m_g = int'(pix[best][15:8]);
        m_b = int'(pix[best][7:0]);
        m_dc = min3(pix[best]);
    endfunction

    task automatic fill(input vec_t v);
        for (int i = 0; i < 64; i++) begin
            pix[i] = 24'(v.base);
            tl[i] = 1'b0;
        end
        if (v.h1 >= 0) pix[v.h1] = 24'(v.p1);
        if (v.h2 >= 0) pix[v.h2] = 24'(v.p2);
        if (v.tla >= 0) tl[v.tla] = 1'b1;
    endtask

    task automatic send_beats(input int n, input int gap, input int top, input bit rclr);
        int i = 0;
        int cyc = 0;
        logic hs;
        while (i < n && cyc < 1000) begin
            @(negedge ACLK);
            axis.tvalid = ($urandom_range(0, 99) >= gap);
            axis.tdata = {top[7:0], pix[i]};
            axis.tlast = tl[i];
            ale_clear = rclr && ($urandom_range(0, 3) == 0);
            hs = axis.tvalid && axis.tready;
            @(posedge ACLK);
            if (hs) i++;
            cyc++;
        end
        if (i < n) chk("beat_timeout", i, n);
    endtask

    task automatic finish_frame(input int er, input int eg, input int eb, input int edc, input int esh, input int ecnt);
        @(negedge ACLK);
        axis.tvalid = 1'b0;
        axis.tlast = 1'b0;
        ale_clear = 1'b0;
        chk("avalid_after_last", A_VALID, 0);
        @(negedge ACLK);
        chk("tready_flush", axis.tready, 0);
        chk("avalid_flush", A_VALID, 0);
        chk("ale_done_flush", ALE_DONE, 0);
        @(negedge ACLK);
        chk("avalid_done", A_VALID, 1);
        chk("ale_done_pulse", ALE_DONE, 1);
        @(negedge ACLK);
        chk("ale_done_single", ALE_DONE, 0);
        chk("avalid_hold", A_VALID, 1);
        chk("A_R", A_R, er);
        chk("A_G", A_G, eg);
        chk("A_B", A_B, eb);
        chk("DC_MAX", DC_MAX, edc);
        chk("FRAME_SHORT", FRAME_SHORT, esh);
        chk("PIX_COUNT", PIX_COUNT, ecnt);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_avalid"}, A_VALID, 0);
        chk({tag, "_ar"}, A_R, 0);
        chk({tag, "_ag"}, A_G, 0);
        chk({tag, "_ab"}, A_B, 0);
        chk({tag, "_dcmax"}, DC_MAX, 0);
        chk({tag, "_pixcnt"}, PIX_COUNT, 0);
        chk({tag, "_short"}, FRAME_SHORT, 0);
        chk({tag, "_tready"}, axis.tready, 0);
    endtask

    task automatic clear_done();
        @(negedge ACLK);
        ale_clear = 1'b1;
        @(negedge ACLK);
        ale_clear = 1'b0;
        check_zero("clr");
    endtask

    initial begin
        vt[0] = '{'h1E140A, 4, 'hC8B4BE, -1, 0, -1, 0, 0, 200, 180, 190, 180, 0, 16};
        vt[1] = '{'h1E140A, 2, 'h649678, 8, 'h82646E, -1, 0, 0, 100, 150, 120, 100, 0, 16};
        vt[2] = '{'h1E140A, 4, 'hC8B4BE, 10, 'hFAFAFA, 7, 0, 0, 200, 180, 190, 180, 1, 8};
        vt[3] = '{'h1E140A, 4, 'hC8B4BE, -1, 0, -1, 50, 0, 200, 180, 190, 180, 0, 16};
        vt[4] = '{'h0A141E, 11, 'h3C4650, -1, 0, -1, 0, 'hFF, 60, 70, 80, 60, 0, 16};
        vt[5] = '{0, -1, 0, -1, 0, -1, 20, 0, 0, 0, 0, 0, 0, 16};
        vt[6] = '{'h1E140A, 0, 'h5A5A5A, -1, 0, 15, 0, 0, 90, 90, 90, 90, 0, 16};
        vt[7] = '{'h1E140A, 15, 'hFFC8D2, 5, 'hC7C7C7, -1, 30, 'hAA, 255, 200, 210, 200, 0, 16};
        axis.tvalid = 1'b0;
        axis.tdata = '0;
        axis.tlast = 1'b0;
        repeat (2) @(negedge ACLK);
        check_zero("reset");
        chk("reset_ale_done", ALE_DONE, 0);
        ARESETn = 1'b1;
        enable = 1'b1;
        for (int v = 0; v < 8; v++) begin
            fill(vt[v]);
            send_beats(vt[v].ecnt, vt[v].gap, vt[v].top, 1'b0);
            finish_frame(vt[v].er, vt[v].eg, vt[v].eb, vt[v].edc, vt[v].esh, vt[v].ecnt);
            if (v == 2) begin
                repeat (4) begin
                    @(negedge ACLK);
                    axis.tvalid = 1'b1;
                    axis.tdata = 32'hFFFF_FFFF;
                    axis.tlast = 1'($urandom_range(0, 1));
                    chk("tready_done", axis.tready, 1);
                end
                @(negedge ACLK);
                axis.tvalid = 1'b0;
                chk("done_beats_ar", A_R, 200);
                chk("done_beats_dcmax", DC_MAX, 180);
                chk("done_beats_pixcnt", PIX_COUNT, 8);
                chk("done_beats_short", FRAME_SHORT, 1);
                chk("done_beats_avalid", A_VALID, 1);
            end
            clear_done();
        end
        fill(vt[0]);
        send_beats(7, 0, 0, 1'b0);
        @(negedge ACLK);
        axis.tvalid = 1'b0;
        chk("pre_rst_pixcnt", PIX_COUNT, 7);
        chk("pre_rst_dcmax", DC_MAX, 180);
        #2 ARESETn = 1'b0;
        #1 check_zero("async_rst");
        @(negedge ACLK);
        ARESETn = 1'b1;
        send_beats(16, 0, 0, 1'b0);
        finish_frame(200, 180, 190, 180, 0, 16);
        clear_done();
        send_beats(7, 0, 0, 1'b0);
        @(negedge ACLK);
        axis.tvalid = 1'b0;
        chk("pre_dis_dcmax", DC_MAX, 180);
        enable = 1'b0;
        @(negedge ACLK);
        check_zero("disable");
        enable = 1'b1;
        send_beats(16, 0, 0, 1'b0);
        finish_frame(200, 180, 190, 180, 0, 16);
        clear_done();
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 64; i++) begin
                pix[i] = (k % 2 == 0) ? 24'($urandom) :
                         {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
                tl[i] = ($urandom_range(0, 5) == 0);
            end
            model();
            send_beats(m_len, $urandom_range(0, 70), $urandom_range(0, 255), 1'b1);
            finish_frame(m_r, m_g, m_b, m_dc, m_short, m_len);
            clear_done();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
